// File: rtl/branch_pc_unit.sv
// branch_pc_unit: resolves branch/jump conditions from the comparator flags,
// owns the architectural PC, squashes younger instructions after a taken
// redirect, and keeps resolved/taken branch statistics.
// Optional build macro: MISALIGN_TRAP_EN -- a taken target with bit 1 set
// raises misalign_trap instead of redirecting.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_valid,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [2:0]  br_funct3,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_imm,
  input  logic [31:0] jalr_base,
  input  logic        BrEq,
  input  logic        BrLT,
  output logic        BrUn,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        redirect,
  output logic        flush,
  output logic        illegal_br,
  output logic        misalign_trap,
  output logic [31:0] br_total,
  output logic [31:0] br_taken
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [2:0] FLUSH_CNT = 3'(FLUSH_DEPTH);

  state_t      state, stateNext;
  logic [2:0]  fcnt, fcntNext;
  logic [31:0] pcNext;
  logic        condTaken, illegalCond;
  logic        isJump, taken, accept, doRedirect, misaligned;
  logic [31:0] target;

  // Unsigned compare for BLTU/BGEU; the comparator needs it this cycle.
  assign BrUn     = br_funct3[1];
  assign pc_plus4 = pc + 32'd4;
  assign flush    = (state == FLUSH);

  // Conditional branch outcome from the comparator flags.
  always_comb begin
    condTaken   = 1'b0;
    illegalCond = 1'b0;
    case (br_funct3)
      3'b000:         condTaken = BrEq;
      3'b001:         condTaken = !BrEq;
      3'b100, 3'b110: condTaken = BrLT;
      3'b101, 3'b111: condTaken = !BrLT;
      default:        illegalCond = 1'b1;
    endcase
  end

  assign isJump = is_jal | is_jalr;
  assign taken  = isJump | condTaken;
  // JALR has priority when both jump flags are set.
  assign target = is_jalr ? ((jalr_base + br_imm) & 32'hFFFF_FFFE)
                          : (br_pc + br_imm);

`ifdef MISALIGN_TRAP_EN
  assign misaligned = target[1];
`else
  assign misaligned = 1'b0;
`endif

  // Branches arriving in the flush window are squashed, never accepted.
  assign accept     = (state == RUN) & br_valid;
  assign doRedirect = accept & taken & !misaligned;

  // Next-state, next-PC and flush counter.
  always_comb begin
    stateNext = state;
    fcntNext  = fcnt;
    pcNext    = pc;
    case (state)
      RUN: begin
        if (doRedirect) begin
          pcNext = target;
          if (FLUSH_DEPTH != 0) begin
            stateNext = FLUSH;
            fcntNext  = FLUSH_CNT;
          end
        end else if (!stall_i) begin
          pcNext = pc_plus4;
        end
      end
      FLUSH: begin
        if (!stall_i) begin
          fcntNext = fcnt - 3'd1;
          pcNext   = pc_plus4;
          if (fcnt <= 3'd1) stateNext = RUN;
        end
      end
      default: stateNext = RUN;
    endcase
  end

  // State, PC, pulse outputs and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      fcnt       <= 3'd0;
      pc         <= RESET_PC;
      redirect   <= 1'b0;
      illegal_br <= 1'b0;
      br_total   <= 32'd0;
      br_taken   <= 32'd0;
    end else begin
      state      <= stateNext;
      fcnt       <= fcntNext;
      pc         <= pcNext;
      redirect   <= doRedirect;
      illegal_br <= accept & !isJump & illegalCond;
      if (accept)     br_total <= br_total + 32'd1;
      if (doRedirect) br_taken <= br_taken + 32'd1;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic trapReg;

  // One-cycle trap pulse for a taken branch/jump with a misaligned target.
  always_ff @(posedge clk) begin
    if (rst) trapReg <= 1'b0;
    else     trapReg <= accept & taken & misaligned;
  end

  assign misalign_trap = trapReg;
`else
  assign misalign_trap = 1'b0;
`endif

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Downstream consumer of the branch comparator. Drives the comparator's BrUn, takes its BrEq/BrLT, and resolves the branch/jump condition.
- Owns the architectural PC register, computes the redirect target, and squashes younger in-flight instructions for a fixed number of cycles after a taken redirect.
- Also keeps branch statistics counters.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_DEPTH, 2, younger instructions squashed after a taken redirect (0..7; 0 = no flush window).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- stall_i  in  1  hold PC; no increment
- br_valid  in  1  resolving branch/jump present this cycle
- is_jal  in  1  instruction is JAL
- is_jalr  in  1  instruction is JALR
- br_funct3  in  3  branch funct3
- br_pc  in  32  PC of resolving instruction
- br_imm  in  32  sign-extended immediate
- jalr_base  in  32  rs1 value for JALR
- BrEq  in  1  from comparator
- BrLT  in  1  from comparator
- BrUn  out  1  to comparator; unsigned compare select
- pc  out  32  current fetch PC
- pc_plus4  out  32  pc + 4
- redirect  out  1  one-cycle pulse: PC was loaded with a target
- flush  out  1  squash younger instruction this cycle
- illegal_br  out  1  one-cycle pulse: funct3 010/011 on a conditional branch
- misalign_trap  out  1  see Optional Feature
- br_total  out  32  resolved branch/jump count
- br_taken  out  32  taken branch/jump count

Behaviour:
- Reset (rst=1 at clk edge):
  - pc=RESET_PC; redirect=0, flush=0, illegal_br=0, misalign_trap=0; br_total=0, br_taken=0; state=RUN.
  - Reset mid-flush aborts the flush window immediately.
- BrUn is combinational: BrUn = br_funct3[1]. Zero latency, so the comparator sees it in the same cycle.
- Condition, used when br_valid=1 and neither is_jal nor is_jalr:
  - 000 taken=BrEq; 001 taken=!BrEq
  - 100/110 taken=BrLT; 101/111 taken=!BrLT
  - 010/011: taken=0 and illegal_br pulses the next cycle.
- Jumps: is_jal or is_jalr gives taken=1, and funct3 is ignored. If both are asserted, is_jalr wins.
- Target, all arithmetic modulo 2^32 (wrap allowed, no overflow flag):
  - Branch/JAL: br_pc + br_imm.
  - JALR: (jalr_base + br_imm) & 32'hFFFF_FFFE.
- States: RUN, FLUSH. Counter fcnt is 3 bits.
- RUN:
  - br_valid & taken: at the next edge, pc<=target and redirect=1 for one cycle (registered).
    - If FLUSH_DEPTH>0: fcnt<=FLUSH_DEPTH and go to FLUSH; otherwise stay in RUN.
  - Otherwise: pc<=pc+4 if !stall_i, else pc holds.
  - A redirect overrides stall_i.
- FLUSH:
  - flush=1 while in FLUSH.
  - br_valid is ignored (the instruction is squashed), and the counters do not count it.
  - When !stall_i: fcnt decrements and pc<=pc+4. At fcnt==1 with a decrement, go to RUN.
  - When stall_i: fcnt and pc hold.
- Counters:
  - br_total increments on every br_valid accepted in RUN.
  - br_taken increments on every accepted taken branch/jump.
  - Both wrap at 2^32.
- pc_plus4 = pc + 4 (combinational, wraps).

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A taken target with target[1]=1 does not redirect: pc keeps its normal increment/hold.
  - misalign_trap pulses for one cycle.
  - br_taken is not incremented, and FLUSH is not entered.
- Undefined:
  - misalign_trap is tied to 0.
  - The redirect happens to the computed target unchanged.

Test Plan:
- rst held 2 cycles, RESET_PC=32'h0000_0100, then 3 free cycles -> pc 0x100, 0x104, 0x108, 0x10C; redirect=0, flush=0.
- BEQ (funct3 000), BrEq=1, br_pc=0x200, br_imm=-8, FLUSH_DEPTH=2 -> next cycle pc=0x1F8 and redirect=1; flush=1 for 2 cycles; br_taken=1, br_total=1.
- BGEU (funct3 111), BrLT=1 -> BrUn=1 the same cycle; not taken; pc increments; br_total+1, br_taken unchanged.
- JALR with jalr_base=0x1001, br_imm=4 -> pc=0x1004. With MISALIGN_TRAP_EN: base=0x1002, imm=0 -> misalign_trap=1 and no redirect. Without the macro: pc=0x1002.
- Taken branch during FLUSH, and stall_i=1 during FLUSH -> branch ignored; flush stays high while stalled with fcnt held; pc held.
- funct3 010 with br_valid -> illegal_br pulse, no redirect. rst asserted in FLUSH -> flush=0 and pc=RESET_PC at the next edge.
